// File: rtl/multi_mode_multiplier_pipe.sv
// multi_mode_multiplier_pipe: per-beat LOW/HIGH/SQUARE/FULL limb multiplier with a credit-checked FWFT output FIFO.
// Defining MMM_OVF_CHECK_EN adds the o_ovf redundant-form flag, carried alongside each result.
module multi_mode_multiplier_pipe #(
    parameter int NUM_ELEMENTS = 33,
    parameter int DSP_BIT_LEN  = 17,
    parameter int WORD_LEN     = 16,
    parameter int MUL_STAGES   = 3,
    parameter int FIFO_DEPTH   = 8,
    parameter int TAG_W        = 4
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst_n,
    input  logic                                          i_val,
    output logic                                          o_rdy,
    input  logic [1:0]                                    i_mode,
    input  logic [TAG_W-1:0]                              i_tag,
    input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]      i_dat_a,
    input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]      i_dat_b,
    input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]      i_add_term,
    output logic                                          o_val,
    input  logic                                          i_rdy,
    output logic [1:0]                                    o_mode,
    output logic [TAG_W-1:0]                              o_tag,
    output logic [2*NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]    o_dat
`ifdef MMM_OVF_CHECK_EN
    ,
    output logic                                          o_ovf
`endif
);
    localparam int N = NUM_ELEMENTS;
    localparam int D = DSP_BIT_LEN;
    localparam int W = WORD_LEN;
    localparam int LAT = MUL_STAGES + 3;
    localparam int PS = LAT - 1;
    localparam int PW = 2 * D + 1;
    localparam int COL_W = 2 * D + $clog2(N + 1) + 1;
    localparam int V_W = COL_W + 1;
    localparam int PTR_W = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [1:0] LOW = 2'd0, HIGH = 2'd1, SQUARE = 2'd2;

    typedef logic [N-1:0][D-1:0] limbs_t;
    typedef logic [2*N-1:0][D-1:0] res_t;
    typedef struct packed {
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
`ifdef MMM_OVF_CHECK_EN
        logic             ovf;
`endif
    } side_t;
    typedef struct packed {
        side_t side;
        res_t  dat;
    } entry_t;

    logic [PS-1:0]    vld_q, vld_d;
    side_t            side_q [PS], side_d [PS];
    limbs_t           a_q, a_d, b_q, b_d;
    limbs_t           add_q [MUL_STAGES+1], add_d [MUL_STAGES+1];
    logic [PW-1:0]    prod_q [MUL_STAGES][N][N], prod_d [MUL_STAGES][N][N];
    logic [COL_W-1:0] col_q [2*N], col_d [2*N];
    entry_t           mem_q [FIFO_DEPTH], mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q;
    logic             accept, push, pop;
    logic [V_W-1:0]   v, c;
    res_t             res;
    entry_t           head;

    always_comb begin
        head = mem_q[rd_q];
        o_val = cnt_q != '0;
        // credits cover every beat already in the pipeline, so the FIFO can never overflow
        o_rdy = rdy_q && ($countones(vld_q) + int'(cnt_q) < FIFO_DEPTH);
        accept = i_val && o_rdy;
        pop = o_val && i_rdy;
        push = vld_q[PS-1];
        vld_d = {vld_q[PS-2:0], accept};
        side_d[0].mode = i_mode;
        side_d[0].tag = i_tag;
`ifdef MMM_OVF_CHECK_EN
        side_d[0].ovf = 1'b0;
        for (int i = 0; i < N - 1; i++)
            side_d[0].ovf = side_d[0].ovf || (i_dat_a[i][D-1] && i_dat_a[i+1] != '0) ||
                            (i_dat_b[i][D-1] && i_dat_b[i+1] != '0) || (i_add_term[i][D-1] && i_add_term[i+1] != '0);
        o_ovf = o_val && head.side.ovf;
`endif
        for (int s = 1; s < PS; s++) side_d[s] = side_q[s-1];
        a_d = i_dat_a;
        b_d = i_dat_b;
        add_d[0] = i_add_term;
        for (int s = 1; s <= MUL_STAGES; s++) add_d[s] = add_q[s-1];
        mem_d = mem_q;
        if (push) mem_d[wr_q] = '{side: side_q[PS-1], dat: res};
        wr_d = push ? (wr_q == PTR_W'(FIFO_DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d = pop ? (rd_q == PTR_W'(FIFO_DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        o_mode = head.side.mode;
        o_tag = head.side.tag;
        o_dat = head.dat;
    end

    // SQUARE keeps only the upper triangle and doubles the off-diagonal terms
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod_d[0][i][j] = PW'(a_q[i]) * PW'(side_q[0].mode == SQUARE ? a_q[j] : b_q[j]);
                if ((side_q[0].mode == LOW && i + j >= N) || (side_q[0].mode == HIGH && i + j < N - 1) ||
                    (side_q[0].mode == SQUARE && i > j))
                    prod_d[0][i][j] = '0;
                else if (side_q[0].mode == SQUARE && i < j)
                    prod_d[0][i][j] = prod_d[0][i][j] << 1;
            end
        end
        for (int s = 1; s < MUL_STAGES; s++) prod_d[s] = prod_q[s-1];
    end

    always_comb begin
        for (int k = 0; k < 2 * N; k++) col_d[k] = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                col_d[i+j] = col_d[i+j] + COL_W'(prod_q[MUL_STAGES-1][i][j]);
        for (int k = 0; k < N; k++)
            col_d[side_q[MUL_STAGES].mode == HIGH ? k + N : k] =
                col_d[side_q[MUL_STAGES].mode == HIGH ? k + N : k] + COL_W'(add_q[MUL_STAGES][k]);
    end

    // carries ripple through every column so each limb is normalised; the top limb absorbs the rest
    always_comb begin
        c = '0;
        v = '0;
        for (int k = 0; k < 2 * N; k++) begin
            v = V_W'(col_q[k]) + c;
            res[k] = (k == 2 * N - 1) ? v[D-1:0] : D'(v[W-1:0]);
            c = v >> W;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
            rdy_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        side_q <= side_d;
        a_q <= a_d;
        b_q <= b_d;
        add_q <= add_d;
        prod_q <= prod_d;
        col_q <= col_d;
        mem_q <= mem_d;
    end
endmodule
